// File: rtl/alu.sv
// LR35902-style ALU: 18 byte/word operations on X/Y with flag nibble {Z,N,H,C}.
// Single registered stage; result and flags appear one clock after the inputs.
module alu (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  op,
    input  logic [15:0] X,
    input  logic [15:0] Y,
    input  logic [3:0]  F,
    output logic [3:0]  FResult,
    output logic [15:0] O
);
    localparam logic [4:0] OR    = 5'd0;
    localparam logic [4:0] AND   = 5'd1;
    localparam logic [4:0] XOR   = 5'd2;
    localparam logic [4:0] CPL   = 5'd3;
    localparam logic [4:0] ADD   = 5'd4;
    localparam logic [4:0] ADC   = 5'd5;
    localparam logic [4:0] SUB   = 5'd6;
    localparam logic [4:0] SBC   = 5'd7;
    localparam logic [4:0] RLC   = 5'd8;
    localparam logic [4:0] RL    = 5'd9;
    localparam logic [4:0] RRC   = 5'd10;
    localparam logic [4:0] RR    = 5'd11;
    localparam logic [4:0] SLA   = 5'd12;
    localparam logic [4:0] SRA   = 5'd13;
    localparam logic [4:0] SRL   = 5'd14;
    localparam logic [4:0] SWAP  = 5'd15;
    localparam logic [4:0] DAA   = 5'd16;
    localparam logic [4:0] ADD16 = 5'd17;

    logic [7:0]  a, b, r, daaAdj;
    logic        cin, useCarry;
    logic [8:0]  sum9, diff9;
    logic [4:0]  halfSum;
    logic [16:0] sum17;
    logic [12:0] sum13;
    logic [15:0] nextO;
    logic [3:0]  nextF;
    logic        daaC;

    assign a   = X[7:0];
    assign b   = Y[7:0];
    assign cin = F[0];
    assign useCarry = (op == ADC) || (op == SBC);

    // Shared adder/subtractor; carry-in only participates for ADC/SBC.
    always_comb begin
        sum9    = {1'b0, a} + {1'b0, b} + {8'd0, useCarry & cin};
        halfSum = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, useCarry & cin};
        diff9   = {1'b0, a} - {1'b0, b} - {8'd0, useCarry & cin};
        sum17   = {1'b0, X} + {1'b0, Y};
        sum13   = {1'b0, X[11:0]} + {1'b0, Y[11:0]};
    end

    // Decimal adjust: correction derived from the original a and incoming N/H/C.
    always_comb begin
        daaAdj = 8'h00;
        daaC   = cin;
        if (!F[2]) begin
            if (cin || a > 8'h99) begin
                daaAdj = daaAdj + 8'h60;
                daaC   = 1'b1;
            end
            if (F[1] || a[3:0] > 4'd9)
                daaAdj = daaAdj + 8'h06;
        end else begin
            if (cin)  daaAdj = daaAdj - 8'h60;
            if (F[1]) daaAdj = daaAdj - 8'h06;
        end
    end

    always_comb begin
        r     = 8'h00;
        nextF = F;
        case (op)
            OR:   begin r = a | b; nextF = {r == 8'h00, 3'b000}; end
            AND:  begin r = a & b; nextF = {r == 8'h00, 3'b010}; end
            XOR:  begin r = a ^ b; nextF = {r == 8'h00, 3'b000}; end
            CPL:  begin r = ~a;    nextF = {F[3], 2'b11, F[0]}; end
            ADD, ADC: begin
                r     = sum9[7:0];
                nextF = {r == 8'h00, 1'b0, halfSum[4], sum9[8]};
            end
            SUB, SBC: begin
                r     = diff9[7:0];
                nextF = {r == 8'h00, 1'b1,
                         {1'b0, a[3:0]} < ({1'b0, b[3:0]} + {4'd0, useCarry & cin}),
                         {1'b0, a} < ({1'b0, b} + {8'd0, useCarry & cin})};
            end
            RLC:  begin r = {a[6:0], a[7]}; nextF = {r == 8'h00, 2'b00, a[7]}; end
            RL:   begin r = {a[6:0], cin};  nextF = {r == 8'h00, 2'b00, a[7]}; end
            RRC:  begin r = {a[0], a[7:1]}; nextF = {r == 8'h00, 2'b00, a[0]}; end
            RR:   begin r = {cin, a[7:1]};  nextF = {r == 8'h00, 2'b00, a[0]}; end
            SLA:  begin r = {a[6:0], 1'b0}; nextF = {r == 8'h00, 2'b00, a[7]}; end
            SRA:  begin r = {a[7], a[7:1]}; nextF = {r == 8'h00, 2'b00, a[0]}; end
            SRL:  begin r = {1'b0, a[7:1]}; nextF = {r == 8'h00, 2'b00, a[0]}; end
            SWAP: begin r = {a[3:0], a[7:4]}; nextF = {r == 8'h00, 3'b000}; end
            DAA:  begin r = a + daaAdj; nextF = {r == 8'h00, F[2], 1'b0, daaC}; end
            ADD16: nextF = {F[3], 1'b0, sum13[12], sum17[16]};
            default: begin r = 8'h00; nextF = F; end
        endcase
    end

    assign nextO = (op == ADD16) ? sum17[15:0] : {8'h00, r};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            O       <= 16'h0000;
            FResult <= 4'b0000;
        end else begin
            O       <= nextO;
            FResult <= nextF;
        end
    end
endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: expected results queued at drive time, checked one edge later.
module tb_alu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  op = 5'd0;
    logic [15:0] X = 16'h0, Y = 16'h0;
    logic [3:0]  F = 4'h0;
    logic [3:0]  FResult;
    logic [15:0] O;

    int nCmp = 0;
    int nBad = 0;

    typedef struct {
        string       tag;
        logic [15:0] o;
        logic [3:0]  f;
    } expT;
    expT sb[$];

    alu dut (.clk(clk), .reset(reset), .op(op), .X(X), .Y(Y), .F(F),
             .FResult(FResult), .O(O));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] expO, input logic [3:0] expF);
        nCmp++;
        assert (O === expO) else begin
            nBad++;
            $error("FAIL %s O: got %h want %h", tag, O, expO);
        end
        nCmp++;
        assert (FResult === expF) else begin
            nBad++;
            $error("FAIL %s FResult: got %b want %b", tag, FResult, expF);
        end
    endtask

    // Drive one op now, let one edge capture it, then pop and compare.
    task automatic step(input string tag, input logic [4:0] o, input logic [15:0] x,
                        input logic [15:0] y, input logic [3:0] f,
                        input logic [15:0] expO, input logic [3:0] expF);
        expT e;
        op = o; X = x; Y = y; F = f;
        e.tag = tag; e.o = expO; e.f = expF;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            nCmp++; nBad++;
            $error("FAIL %s scoreboard empty: got 0 entries want 1", tag);
        end else begin
            e = sb.pop_front();
            check(e.tag, e.o, e.f);
        end
    endtask

    initial begin
        logic [15:0] rx, ry;
        logic [16:0] s17;
        logic [12:0] s13;
        logic [7:0]  ra, rb;

        // Reset state, including across an edge while held
        #2;
        check("reset_init", 16'h0000, 4'b0000);
        op = 5'd4; X = 16'h00FF; Y = 16'h00FF; F = 4'hF;
        @(posedge clk); #1;
        check("reset_held", 16'h0000, 4'b0000);
        @(negedge clk);
        reset = 1'b0;

        // Test plan vectors
        step("add",    5'd4,  16'h003A, 16'h00C6, 4'b0000, 16'h0000, 4'b1011);
        step("sub",    5'd6,  16'h003E, 16'h003E, 4'b0000, 16'h0000, 4'b1100);
        step("sbc",    5'd7,  16'h003B, 16'h002A, 4'b0001, 16'h0010, 4'b0100);
        step("adc",    5'd5,  16'h00E1, 16'h000F, 4'b0001, 16'h00F1, 4'b0010);
        step("daa1",   5'd16, 16'h007D, 16'h0000, 4'b0000, 16'h0083, 4'b0000);
        step("daa2",   5'd16, 16'h009A, 16'h0000, 4'b0000, 16'h0000, 4'b1001);
        step("add16a", 5'd17, 16'h8A23, 16'h0605, 4'b1000, 16'h9028, 4'b1010);
        step("add16b", 5'd17, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011);
        step("rl",     5'd9,  16'h0080, 16'h0000, 4'b0000, 16'h0000, 4'b1001);
        step("rr",     5'd11, 16'h0001, 16'h0000, 4'b0001, 16'h0080, 4'b0001);
        step("sra",    5'd13, 16'h008A, 16'h0000, 4'b0000, 16'h00C5, 4'b0000);
        step("swap",   5'd15, 16'h00F0, 16'h0000, 4'b0000, 16'h000F, 4'b0000);
        step("cpl",    5'd3,  16'h0035, 16'h0000, 4'b1001, 16'h00CA, 4'b1111);
        step("and",    5'd1,  16'h005A, 16'h003F, 4'b0000, 16'h001A, 4'b0010);

        // Remaining ops and boundary cases; upper X/Y bytes must not leak into 8-bit ops
        step("or",     5'd0,  16'hFF00, 16'hAA00, 4'b1111, 16'h0000, 4'b1000);
        step("xor",    5'd2,  16'h12F0, 16'h340F, 4'b0000, 16'h00FF, 4'b0000);
        step("rlc",    5'd8,  16'h0085, 16'h0000, 4'b0000, 16'h000B, 4'b0001);
        step("rrc",    5'd10, 16'h0001, 16'h0000, 4'b0000, 16'h0080, 4'b0001);
        step("sla",    5'd12, 16'h0080, 16'h0000, 4'b0000, 16'h0000, 4'b1001);
        step("srl",    5'd14, 16'h0081, 16'h0000, 4'b0001, 16'h0040, 4'b0001);
        step("sbc_brw",5'd7,  16'h0010, 16'h000F, 4'b0001, 16'h0000, 4'b1110);
        step("daa_n",  5'd16, 16'h00AB, 16'h0000, 4'b0111, 16'h0045, 4'b0101);
        step("add_nc", 5'd4,  16'h0001, 16'h0001, 4'b0001, 16'h0002, 4'b0000);
        step("rsv20",  5'd20, 16'h1234, 16'h5678, 4'b0110, 16'h0000, 4'b0110);
        step("rsv31",  5'd31, 16'hFFFF, 16'hFFFF, 4'b1001, 16'h0000, 4'b1001);

        // Random ADD16 and XOR against simple arithmetic expectations
        for (int i = 0; i < 8; i++) begin
            rx = 16'($urandom); ry = 16'($urandom);
            s17 = {1'b0, rx} + {1'b0, ry};
            s13 = {1'b0, rx[11:0]} + {1'b0, ry[11:0]};
            step("rnd_add16", 5'd17, rx, ry, 4'b1111, s17[15:0], {1'b1, 1'b0, s13[12], s17[16]});
            ra = rx[7:0]; rb = ry[7:0];
            step("rnd_xor", 5'd2, rx, ry, 4'b0101, {8'h00, ra ^ rb}, {(ra ^ rb) == 8'h00, 3'b000});
        end

        // Latency: output must still hold the previous result before the capturing edge
        step("lat1", 5'd4, 16'h0011, 16'h0022, 4'b0000, 16'h0033, 4'b0000);
        op = 5'd4; X = 16'h0001; Y = 16'h0001; F = 4'b0000;
        #2;
        check("lat_hold", 16'h0033, 4'b0000);
        step("lat2", 5'd4, 16'h0001, 16'h0001, 4'b0000, 16'h0002, 4'b0000);
        step("lat3", 5'd0, 16'h0050, 16'h0005, 4'b0000, 16'h0055, 4'b0000);

        // Asynchronous reset between edges while outputs are nonzero
        step("pre_rst", 5'd3, 16'h0000, 16'h0000, 4'b0001, 16'h00FF, 4'b0111);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst", 16'h0000, 4'b0000);
        @(posedge clk); #1;
        check("rst_hold", 16'h0000, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        step("post_rst", 5'd4, 16'h00F0, 16'h0010, 4'b0000, 16'h0000, 4'b1001);

        nCmp++;
        assert (sb.size() == 0) else begin
            nBad++;
            $error("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish before 100000");
        $fatal(1, "timeout");
    end
endmodule
